nebula_csr_access_unit: RTL and testbench
=========================================

NEBULA_CSR_ACCESS_UNIT -- requirements
Module: nebula_csr_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  CSR instruction offered.
REQ-005 SHALL have port req_ready  output  1  unit accepts request.
REQ-006 SHALL have port req_funct3  input  3  Zicsr funct3.
REQ-007 SHALL have port req_csr_addr  input  12  target CSR.
REQ-008 SHALL have port req_rs1_idx  input  5  rs1 index, or zimm for immediate forms.
REQ-009 SHALL have port req_rs1_val  input  XLEN  rs1 value.
REQ-010 SHALL have port req_rd_idx  input  5  destination register.
REQ-011 SHALL have port priv_mode  input  2  current privilege (00 U, 01 S, 11 M).
REQ-012 SHALL have port csr_addr  output  12  address to CSR file.
REQ-013 SHALL have port csr_we  output  1  CSR file write strobe.
REQ-014 SHALL have port csr_wdata  output  XLEN  final value to write.
REQ-015 SHALL have port csr_op  output  2  01 RW, 10 RS, 11 RC, 00 idle.
REQ-016 SHALL have port csr_rdata  input  XLEN  combinational read data from the CSR file.
REQ-017 SHALL have port rsp_valid  output  1  result available.
REQ-018 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-019 SHALL have port rsp_rd_idx  output  5  captured rd.
REQ-020 SHALL have port rsp_rd_we  output  1  write rd.
REQ-021 SHALL have port rsp_rd_wdata  output  XLEN  old CSR value.
REQ-022 SHALL have port rsp_illegal  output  1  illegal-instruction exception.
REQ-023 SHALL have port rsp_tval  output  XLEN  zero-extended csr address when illegal, else 0.

Function
REQ-024 SHALL implement FSM IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-025 SHALL, in IDLE with req_valid, capture all req_* fields and priv_mode, then enter READ.
REQ-026 SHALL drive csr_addr = captured address in READ and WRITE, 0 otherwise.
REQ-027 SHALL, in READ, register csr_rdata as old value and evaluate legality in the same cycle.
REQ-028 SHALL select operand = zero-extended rs1_idx (zimm) when funct3[2]=1, else rs1_val.
REQ-029 SHALL compute new value: RW operand; RS old|operand; RC old&~operand.
REQ-030 SHALL suppress the write for RS/RC/RSI/RCI when rs1_idx==0; RW/RWI always write.
REQ-031 SHALL flag illegal when funct3 is 000 or 100, or priv_mode < addr[9:8], or addr[11:10]==11 with a non-suppressed write.
REQ-032 SHALL transition READ->WRITE if legal and not suppressed, else READ->RESP.
REQ-033 SHALL assert csr_we for exactly one cycle in WRITE, with csr_wdata = new value and csr_op = funct3[1:0]; otherwise csr_we=0, csr_wdata=0, csr_op=00.
REQ-034 SHALL hold rsp_valid high in RESP with stable rsp_* outputs until rsp_ready, then return to IDLE.
REQ-035 SHALL set rsp_rd_we = legal && rd_idx!=0; rsp_rd_wdata = old value when legal, else 0.
REQ-036 SHALL give latency request-accept to rsp_valid: 3 cycles with write, 2 cycles without or illegal.
REQ-037 SHALL never assert csr_we for an illegal request.
REQ-038 SHALL accept a new request no earlier than the cycle after a response handshake (no overlap).

Reset
REQ-039 SHALL, on rst asserted, go to IDLE asynchronously, aborting any in-flight op without a write.
REQ-040 SHALL reset outputs: req_ready=1, all other outputs 0.
REQ-041 SHALL hold IDLE and ignore req_valid while rst is high.

Verification
REQ-042 CSRRW 0x340, rs1_val=0xA5, rd=5, M-mode, old=0x11 -> csr_we one cycle with wdata 0xA5, op 01; rsp at cycle 3, rd_wdata=0x11, rd_we=1.
REQ-043 CSRRS 0x300, rs1_idx=0, old=0x88 -> no csr_we; rsp at cycle 2, rd_wdata=0x88.
REQ-044 CSRRCI 0x304, zimm=0x08, old=0x8A -> wdata 0x82, op 11.
REQ-045 CSRRW 0xF14 in M-mode -> rsp_illegal=1, tval=0xF14, rd_we=0, no csr_we; CSRRS 0xF14 rs1_idx=0 -> legal read.
REQ-046 CSRRW 0x341 with priv_mode=00 -> illegal, tval=0x341; funct3=100 -> illegal.
REQ-047 rsp_ready low 4 cycles -> rsp outputs stable, req_ready=0; rst pulse during WRITE-bound READ -> no csr_we, IDLE.

Source files
------------

// File: rtl/nebula_csr_access_unit.sv
// rtl/nebula_csr_access_unit.sv - Zicsr read-modify-write sequencer between the pipeline and the CSR file.
// One request at a time: capture, read old value and check legality, optional write, then hold the response.
module nebula_csr_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd_idx,
  input  logic [1:0]      priv_mode,
  output logic [11:0]     csr_addr,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd_idx,
  output logic            rsp_rd_we,
  output logic [XLEN-1:0] rsp_rd_wdata,
  output logic            rsp_illegal,
  output logic [XLEN-1:0] rsp_tval
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] new_q, new_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic            suppress;
  logic            illegal_now;

  // Evaluated against the live csr_rdata; only meaningful while in READ.
  always_comb begin
    operand  = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    suppress = (funct3_q[1:0] != 2'b01) && (rs1_idx_q == 5'd0);
    illegal_now = (funct3_q[1:0] == 2'b00)
               || (priv_q < addr_q[9:8])
               || ((addr_q[11:10] == 2'b11) && !suppress);
    case (funct3_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = csr_rdata | operand;
      2'b11:   new_val = csr_rdata & ~operand;
      default: new_val = csr_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      funct3_q  <= '0;
      addr_q    <= '0;
      rs1_idx_q <= '0;
      rs1_val_q <= '0;
      rd_idx_q  <= '0;
      priv_q    <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      rs1_idx_q <= rs1_idx_d;
      rs1_val_q <= rs1_val_d;
      rd_idx_q  <= rd_idx_d;
      priv_q    <= priv_d;
      old_q     <= old_d;
      new_q     <= new_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    rs1_idx_d = rs1_idx_q;
    rs1_val_d = rs1_val_q;
    rd_idx_d  = rd_idx_q;
    priv_d    = priv_q;
    old_d     = old_q;
    new_d     = new_q;
    illegal_d = illegal_q;
    if (state_q == S_IDLE && req_valid) begin
      funct3_d  = req_funct3;
      addr_d    = req_csr_addr;
      rs1_idx_d = req_rs1_idx;
      rs1_val_d = req_rs1_val;
      rd_idx_d  = req_rd_idx;
      priv_d    = priv_mode;
    end else if (state_q == S_READ) begin
      old_d     = csr_rdata;
      new_d     = new_val;
      illegal_d = illegal_now;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_READ;
      S_READ:  state_d = (!illegal_now && !suppress) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == S_IDLE);
    csr_addr     = '0;
    csr_we       = 1'b0;
    csr_wdata    = '0;
    csr_op       = 2'b00;
    rsp_valid    = 1'b0;
    rsp_rd_idx   = '0;
    rsp_rd_we    = 1'b0;
    rsp_rd_wdata = '0;
    rsp_illegal  = 1'b0;
    rsp_tval     = '0;
    case (state_q)
      S_READ: csr_addr = addr_q;
      S_WRITE: begin
        csr_addr  = addr_q;
        csr_we    = 1'b1;
        csr_wdata = new_q;
        csr_op    = funct3_q[1:0];
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        rsp_rd_idx   = rd_idx_q;
        rsp_rd_we    = !illegal_q && (rd_idx_q != 5'd0);
        rsp_rd_wdata = illegal_q ? '0 : old_q;
        rsp_illegal  = illegal_q;
        rsp_tval     = illegal_q ? {{(XLEN-12){1'b0}}, addr_q} : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nebula_csr_access_unit.sv
// tb/tb_nebula_csr_access_unit.sv - directed and randomized checks of the CSR access unit against a CSR-file model.
module tb_nebula_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_idx;
  logic [63:0] req_rs1_val;
  logic [4:0]  req_rd_idx;
  logic [1:0]  priv_mode;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [63:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [63:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic        rsp_rd_we;
  logic [63:0] rsp_rd_wdata;
  logic        rsp_illegal;
  logic [63:0] rsp_tval;

  logic [63:0] mem [0:4095];
  int vectors = 0;
  int miscompares = 0;

  assign csr_rdata = mem[csr_addr];

  always #5 clk = ~clk;

  nebula_csr_access_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .req_rd_idx(req_rd_idx), .priv_mode(priv_mode),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_op(csr_op),
    .csr_rdata(csr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_idx(rsp_rd_idx),
    .rsp_rd_we(rsp_rd_we), .rsp_rd_wdata(rsp_rd_wdata), .rsp_illegal(rsp_illegal),
    .rsp_tval(rsp_tval)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; expectations come straight from the Zicsr rules.
  task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [63:0] rs1v, input logic [4:0] rd, input logic [1:0] priv,
                        input int delay);
    logic [63:0] old, operand, newv;
    logic        suppress, illegal, write;
    int          op, cyc, we_cnt;
    logic [63:0] wd_seen;
    logic [1:0]  op_seen;
    logic [63:0] snap_wdata, snap_tval;
    logic        snap_ill, snap_we;
    old      = mem[addr];
    op       = int'(f3) % 4;
    operand  = (f3 >= 3'd4) ? 64'(rs1) : rs1v;
    suppress = (op != 1) && (rs1 == 5'd0);
    illegal  = (op == 0) || (int'(priv) < int'(addr[9:8])) || ((addr >> 10) == 12'd3 && !suppress);
    write    = !illegal && !suppress;
    if (op == 1)      newv = operand;
    else if (op == 2) newv = old | operand;
    else              newv = old & ~operand;

    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr; req_rs1_idx = rs1;
    req_rs1_val = rs1v; req_rd_idx = rd; priv_mode = priv;
    @(posedge clk);
    cyc = 0; we_cnt = 0; wd_seen = '0; op_seen = '0;
    while (cyc < 10) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      if (cyc == 1) chk("csr_addr_read", 64'(csr_addr), 64'(addr));
      if (csr_we) begin
        we_cnt++; wd_seen = csr_wdata; op_seen = csr_op;
        mem[csr_addr] = csr_wdata;
      end
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    chk("latency", 64'(cyc), write ? 64'd3 : 64'd2);
    chk("csr_we_count", 64'(we_cnt), write ? 64'd1 : 64'd0);
    if (write) begin
      chk("csr_wdata", wd_seen, newv);
      chk("csr_op", 64'(op_seen), 64'(op));
    end
    chk("csr_file", mem[addr], write ? newv : old);
    chk("rsp_illegal", 64'(rsp_illegal), 64'(illegal));
    chk("rsp_tval", rsp_tval, illegal ? 64'(addr) : 64'd0);
    chk("rsp_rd_we", 64'(rsp_rd_we), 64'(!illegal && rd != 5'd0));
    chk("rsp_rd_wdata", rsp_rd_wdata, illegal ? 64'd0 : old);
    chk("rsp_rd_idx", 64'(rsp_rd_idx), 64'(rd));
    snap_wdata = rsp_rd_wdata; snap_tval = rsp_tval; snap_ill = rsp_illegal; snap_we = rsp_rd_we;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_rd_wdata", rsp_rd_wdata, snap_wdata);
      chk("hold_tval", rsp_tval, snap_tval);
      chk("hold_flags", {62'd0, rsp_illegal, rsp_rd_we}, {62'd0, snap_ill, snap_we});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [11:0] addrs [10];
    logic [1:0]  privs [4];
    logic [63:0] saved;
    addrs = '{12'h340, 12'h300, 12'h304, 12'h341, 12'hF14, 12'h100, 12'h200, 12'hC00, 12'h7C0, 12'hB00};
    privs = '{2'b00, 2'b01, 2'b11, 2'b10};
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0; req_rs1_idx = '0;
    req_rs1_val = '0; req_rd_idx = '0; priv_mode = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_csr", {49'd0, csr_addr, csr_we, csr_op}, 64'd0);
    chk("reset_csr_wdata", csr_wdata, 64'd0);
    chk("reset_rsp", {57'd0, rsp_valid, rsp_rd_idx, rsp_rd_we}, 64'd0);
    chk("reset_rsp_data", rsp_rd_wdata | rsp_tval | 64'(rsp_illegal), 64'd0);
    rst = 1'b0;

    mem[12'h340] = 64'h11;
    do_req(3'b001, 12'h340, 5'd7, 64'hA5, 5'd5, 2'b11, 0);
    mem[12'h300] = 64'h88;
    do_req(3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd6, 2'b11, 1);
    mem[12'h304] = 64'h8A;
    do_req(3'b111, 12'h304, 5'd8, 64'h0, 5'd9, 2'b11, 0);
    do_req(3'b001, 12'hF14, 5'd2, 64'h1234, 5'd3, 2'b11, 0);
    do_req(3'b010, 12'hF14, 5'd0, 64'h0, 5'd3, 2'b11, 0);
    do_req(3'b001, 12'h341, 5'd2, 64'h55, 5'd4, 2'b00, 2);
    do_req(3'b100, 12'h340, 5'd2, 64'h55, 5'd4, 2'b11, 0);
    do_req(3'b001, 12'h340, 5'd1, 64'hDEAD, 5'd1, 2'b11, 4);

    // Reset while a write-bound request is in READ.
    saved = mem[12'h340];
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340; req_rs1_idx = 5'd3;
    req_rs1_val = 64'hBEEF; req_rd_idx = 5'd2; priv_mode = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_idle", 64'(req_ready), 64'd1);
    chk("rst_async_we", 64'(csr_we), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_idle", 64'(req_ready), 64'd1);
      chk("rst_hold_outputs", {62'd0, csr_we, rsp_valid}, 64'd0);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_write", mem[12'h340], saved);
    chk("rst_after_idle", 64'(req_ready), 64'd1);

    for (int n = 0; n < 60; n++) begin
      do_req(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 9)],
             ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             {$urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             privs[$urandom_range(0, 3)], int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
